// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, sequencer states and mode constants
package alu_pkg;

  // Op codes understood by the shared ALU
  localparam logic [3:0] ADD  = 4'b0011;
  localparam logic [3:0] SUB  = 4'b0111;
  localparam logic [3:0] ROL  = 4'b1011;
  localparam logic [3:0] OR   = 4'b0001;
  localparam logic [3:0] AND  = 4'b0101;
  localparam logic [3:0] EOR  = 4'b1001;
  localparam logic [3:0] PASS = 4'b1111;

  // Operation select
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    STEP_A = 1'b0,
    STEP_B = 1'b1
  } step_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/result handshake bundle of the mul/div sequencer
interface alu_muldiv_seq_if;
  logic        start;
  logic        mode;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        div0;

  modport master (output start, mode, opa, opb, input busy, done, result, div0);
  modport slave  (input start, mode, opa, opb, output busy, done, result, div0);
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 8-bit multiply/divide sequencer driving a shared external ALU
module alu_muldiv_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  alu_muldiv_seq_if.slave  req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_op,
  output logic             alu_right,
  output logic [7:0]       alu_ai,
  output logic [7:0]       alu_bi,
  output logic             alu_ci,
  output logic             alu_bcd,
  output logic             alu_rdy,
  input  logic [7:0]       alu_out,
  input  logic             alu_co
);

  state_t      state, state_nxt;
  step_t       step, step_nxt;
  logic [2:0]  cnt, cnt_nxt;

  // hi holds H (mul) or R (div); lo holds L (mul) or Q (div); carry holds C or K
  logic [7:0]  hi, lo, divisor;
  logic        carry;
  logic        mode_q;
  logic [15:0] result_q;
  logic        div0_q;

  logic        accept;
  logic        by_zero;
  logic        last;
  logic        keep;

  assign accept  = (state == IDLE) && req.start;
  assign by_zero = (req.mode == MODE_DIV) && (req.opb == 8'd0);
  assign last    = (cnt == 3'd7);
  assign keep    = carry | alu_co;

  assign req.busy   = (state != IDLE);
  // done is gated by the grant so a stalled DONE cycle cannot stretch the pulse
  assign req.done   = (state == DONE) && alu_gnt;
  assign req.result = result_q;
  assign req.div0   = div0_q;

  assign alu_bcd = 1'b0;
  assign alu_rdy = (state == ISSUE) && alu_gnt;

  // Sequencer state, iteration counter and step register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      step  <= STEP_A;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a withheld grant freezes every non-IDLE state
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req.start) begin
          cnt_nxt   = 3'd0;
          step_nxt  = STEP_A;
          state_nxt = by_zero ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (alu_gnt) state_nxt = CAPT;
      end
      CAPT: begin
        if (alu_gnt) begin
          if (step == STEP_A) begin
            step_nxt  = STEP_B;
            state_nxt = ISSUE;
          end else if (!last) begin
            cnt_nxt   = cnt + 3'd1;
            step_nxt  = STEP_A;
            state_nxt = ISSUE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (alu_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU request for the current step; idle encoding outside ISSUE
  always_comb begin
    alu_op    = PASS;
    alu_right = 1'b0;
    alu_ai    = 8'd0;
    alu_bi    = 8'd0;
    alu_ci    = 1'b0;
    if (state == ISSUE) begin
      alu_ai = hi;
      if (mode_q == MODE_MUL) begin
        if (step == STEP_A) begin
          alu_op = ADD;
          alu_bi = lo[0] ? divisor : 8'd0;
        end else begin
          alu_op    = PASS;
          alu_right = 1'b1;
          alu_ci    = carry;
        end
      end else begin
        if (step == STEP_A) begin
          alu_op = ROL;
          alu_ci = lo[7];
        end else begin
          alu_op = SUB;
          alu_bi = divisor;
          alu_ci = 1'b1;
        end
      end
    end
  end

  // Operand capture, per-step register update and final result latch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi       <= 8'd0;
      lo       <= 8'd0;
      carry    <= 1'b0;
      divisor  <= 8'd0;
      mode_q   <= MODE_MUL;
      result_q <= 16'd0;
      div0_q   <= 1'b0;
    end else if (accept) begin
      mode_q  <= req.mode;
      divisor <= req.opb;
      hi      <= 8'd0;
      lo      <= req.opa;
      carry   <= 1'b0;
      div0_q  <= by_zero;
      if (by_zero) result_q <= {req.opa, 8'hFF};
    end else if (state == CAPT && alu_gnt) begin
      if (mode_q == MODE_MUL) begin
        if (step == STEP_A) begin
          hi    <= alu_out;
          carry <= alu_co;
        end else begin
          hi <= alu_out;
          lo <= {alu_co, lo[7:1]};
          if (last) result_q <= {alu_out, alu_co, lo[7:1]};
        end
      end else begin
        if (step == STEP_A) begin
          hi    <= alu_out;
          carry <= alu_co;
          lo    <= {lo[6:0], 1'b0};
        end else begin
          // restore-free division: take the difference only when it fits
          if (keep) begin
            hi    <= alu_out;
            lo[0] <= 1'b1;
          end
          if (last) result_q <= keep ? {alu_out, lo[7:1], 1'b1} : {hi, lo};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with a behavioural ALU
module tb_alu_muldiv_seq;

  logic       clk;
  logic       reset_n;
  logic       alu_gnt;
  logic [3:0] alu_op;
  logic       alu_right;
  logic [7:0] alu_ai, alu_bi;
  logic       alu_ci, alu_bcd, alu_rdy;
  logic [7:0] alu_out;
  logic       alu_co;
  logic [8:0] alu_sum;

  int n_assert;
  int n_fail;

  logic       r_m;
  logic [7:0] r_a, r_b;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.slave),
    .alu_gnt   (alu_gnt),
    .alu_op    (alu_op),
    .alu_right (alu_right),
    .alu_ai    (alu_ai),
    .alu_bi    (alu_bi),
    .alu_ci    (alu_ci),
    .alu_bcd   (alu_bcd),
    .alu_rdy   (alu_rdy),
    .alu_out   (alu_out),
    .alu_co    (alu_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: registered result and carry, loaded only when alu_rdy is high
  always @(posedge clk) begin
    if (alu_rdy) begin
      case (alu_op)
        4'b0011: alu_sum = {1'b0, alu_ai} + {1'b0, alu_bi} + {8'd0, alu_ci};
        4'b0111: alu_sum = {1'b0, alu_ai} + {1'b0, ~alu_bi} + {8'd0, alu_ci};
        4'b1011: alu_sum = {alu_ai, alu_ci};
        4'b1111: alu_sum = alu_right ? {alu_ai[0], alu_ci, alu_ai[7:1]} : {1'b0, alu_ai};
        default: alu_sum = 9'd0;
      endcase
      alu_out <= alu_sum[7:0];
      alu_co  <= alu_sum[8];
    end
  end

  function automatic logic [15:0] ref_result(input logic m, input logic [7:0] a, input logic [7:0] b);
    if (!m) return 16'(a) * 16'(b);
    if (b == 8'd0) return {a, 8'hFF};
    return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_div0"}, 32'(bus.div0), 32'd0);
    chk({tag, "_rdy"}, 32'(alu_rdy), 32'd0);
  endtask

  // One operation from start to done; optional grant stalls, a start pulse while busy, or a reset
  task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                        input int stalls, input int busy_start_at, input int reset_at, input string tag);
    int          lat;
    int          stalls_left;
    int          exp_lat;
    logic        rdy_any;
    logic        seen;
    logic        late_done;
    logic [15:0] exp_res;
    exp_res     = ref_result(m, a, b);
    exp_lat     = (m && b == 8'd0) ? 1 : 33 + stalls;
    lat         = 0;
    stalls_left = stalls;
    rdy_any     = 1'b0;
    seen        = 1'b0;
    bus.mode    = m;
    bus.opa     = a;
    bus.opb     = b;
    bus.start   = 1'b1;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        bus.opa   = 8'($urandom);
        bus.opb   = 8'($urandom);
        bus.mode  = 1'($urandom);
      end
      if (busy_start_at != 0 && lat == busy_start_at) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.opb   = 8'd0;
      end
      if (busy_start_at != 0 && lat == busy_start_at + 1) bus.start = 1'b0;
      if (reset_at != 0 && lat == reset_at) begin
        reset_n   = 1'b0;
        alu_gnt   = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        alu_gnt = 1'b1;
        chk_idle_state({tag, "_after_reset"});
        late_done = 1'b0;
        repeat (40) begin
          @(posedge clk);
          #1;
          if (bus.done || bus.busy) late_done = 1'b1;
        end
        chk({tag, "_no_done_after_reset"}, 32'(late_done), 32'd0);
        return;
      end
      rdy_any = rdy_any | alu_rdy;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (stalls_left > 0 && lat >= 2 && ($urandom_range(0, 2) == 0 || lat >= 25)) begin
          alu_gnt = 1'b0;
          stalls_left--;
          #1;
          chk({tag, "_rdy_stall"}, 32'(alu_rdy), 32'd0);
        end else begin
          alu_gnt = 1'b1;
        end
      end
    end
    alu_gnt = 1'b1;
    chk({tag, "_latency"}, seen ? lat : 999, exp_lat);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_div0"}, 32'(bus.div0), 32'(m && b == 8'd0));
    if (m && b == 8'd0) chk({tag, "_no_issue"}, 32'(rdy_any), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'({bus.done, bus.busy}), 32'd0);
    chk({tag, "_held"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    alu_out   = 8'd0;
    alu_co    = 1'b0;
    alu_sum   = 9'd0;
    reset_n   = 1'b0;
    alu_gnt   = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.opa   = 8'd0;
    bus.opb   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_state("reset");
    chk("reset_alu_idle", 32'({alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd}),
        32'({4'hF, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}));
    reset_n = 1'b1;
    alu_gnt = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 8'h0D, 8'h0B, 0, 0, 0, "mul_0d_0b");
    chk("mul_0d_0b_const", 32'(bus.result), 32'h008F);
    run_op(1'b0, 8'hFF, 8'hFF, 0, 0, 0, "mul_ff_ff");
    chk("mul_ff_ff_const", 32'(bus.result), 32'hFE01);
    run_op(1'b0, 8'h00, 8'h5A, 0, 0, 0, "mul_00_5a");
    run_op(1'b1, 8'd200, 8'd7, 0, 0, 0, "div_200_7");
    chk("div_200_7_const", 32'(bus.result), 32'h041C);
    run_op(1'b1, 8'hFF, 8'h01, 0, 0, 0, "div_ff_01");
    run_op(1'b1, 8'h05, 8'h80, 0, 0, 0, "div_05_80");
    run_op(1'b1, 8'h37, 8'h00, 0, 0, 0, "div_by_zero");
    chk("div_by_zero_const", 32'(bus.result), 32'h37FF);
    run_op(1'b0, 8'h0D, 8'h0B, 5, 0, 0, "mul_stall");
    run_op(1'b1, 8'd200, 8'd7, 0, 5, 0, "div_busy_start");
    run_op(1'b1, 8'd99, 8'd10, 0, 5, 10, "div_reset");
    run_op(1'b1, 8'd99, 8'd10, 0, 0, 0, "div_after_reset");

    for (int i = 0; i < 16; i++) begin
      r_m = 1'($urandom);
      r_a = 8'($urandom);
      r_b = (i == 5) ? 8'd0 : 8'($urandom);
      run_op(r_m, r_a, r_b, (i % 3 == 0) ? 3 : 0, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 mode  input  1  0 = unsigned 8x8 multiply, 1 = unsigned 8/8 divide.
REQ-005 opa  input  8  multiplicand / dividend; captured on the accepted start.
REQ-006 opb  input  8  multiplier / divisor; captured on the accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-008 done  output  1  one-cycle pulse; results valid in the same cycle.
REQ-009 result  output  16  MUL: product; DIV: {remainder, quotient}; held until the next accepted start.
REQ-010 div0  output  1  divide-by-zero flag; held with result.
REQ-011 alu_gnt  input  1  shared-ALU grant; 0 freezes the sequencer.
REQ-012 alu_op  output  4  ALU op: 0011 add, 0111 sub, 1011 rotate-left (AI+AI+CI), 1111 pass.
REQ-013 alu_right  output  1  ALU right-rotate select (OUT = {CI, AI[7:1]}, CO = AI[0]).
REQ-014 alu_ai, alu_bi  output  8 each  ALU operands.
REQ-015 alu_ci  output  1  ALU carry in.
REQ-016 alu_bcd  output  1  tied 0.
REQ-017 alu_rdy  output  1  ALU register enable; equals 1 only in ISSUE cycles with alu_gnt=1.
REQ-018 alu_out  input  8  registered ALU result; valid the cycle after an issue.
REQ-019 alu_co  input  1  registered ALU carry; valid the cycle after an issue.

Function
REQ-020 States: IDLE, ISSUE, CAPT, DONE; 3-bit iteration counter; 1-bit step (A/B) within an iteration.
REQ-021 IDLE + start=1: capture opa/opb/mode, clear counter and step, and go to ISSUE; if mode=1 and opb=0, go to DONE instead.
REQ-022 ISSUE drives the ALU for the current step; the next state is CAPT.
REQ-023 CAPT latches alu_out/alu_co into internal registers.
REQ-024 CAPT exit: after step A, go to ISSUE for step B; after step B with counter<7, increment the counter and go to ISSUE for step A; after step B with counter=7, go to DONE.
REQ-025 DONE: done=1 for one cycle; go to IDLE.
REQ-026 MUL, internal registers: H = 0, L = opa.
  - Step A: add, AI=H, BI = L[0] ? opb : 0, CI=0; capture H and carry C.
  - Step B: pass with right=1, AI=H, CI=C; capture H and the shifted-out bit s; L <= {s, L[7:1]}.
  - result = {H, L}.
REQ-027 DIV, internal registers: R = 0, Q = opa.
  - Step A: rotate-left, AI=R, CI=Q[7]; capture R and the shift carry K; Q <= {Q[6:0], 0}.
  - Step B: sub, AI=R, BI=opb, CI=1.
  - If K | alu_co: R <= alu_out, Q[0] <= 1; else R and Q are unchanged.
  - result = {R, Q}.
REQ-028 Latency, alu_gnt held 1: MUL and DIV assert done exactly 33 cycles after the start cycle; divide-by-zero asserts done 1 cycle after it.
REQ-029 Divide-by-zero: result = {opa, 8'hFF}, div0=1; the ALU is never issued.
REQ-030 alu_gnt=0 in any state other than IDLE: all state, counters and registers hold and alu_rdy=0; latency extends by exactly one cycle per stalled cycle.
REQ-031 start is ignored while busy=1 (ISSUE, CAPT, DONE).
REQ-032 div0 clears on the next accepted start.
REQ-033 Outside ISSUE, alu_op = 1111, alu_right = 0, and alu_ai, alu_bi, alu_ci = 0.

Reset
REQ-034 reset_n=0 at a clock edge forces IDLE, counter = 0, step = A, busy = 0, done = 0, result = 0, div0 = 0, alu_rdy = 0, independent of alu_gnt.
REQ-035 Reset mid-operation abandons the operation; no done pulse follows.

Structure
REQ-036 The shared package alu_pkg holds:
  - ALU op code constants: ADD, SUB, ROL, OR, AND, EOR, PASS.
  - Sequencer state encoding.
  - Mode constants.
REQ-037 No sub-module: the ALU stays outside, shared with the CPU core and arbitrated via alu_gnt; the sequencer is one FSM plus a datapath.

Verification
REQ-038 MUL 0x0D x 0x0B, gnt=1 -> done at start+33, result 0x008F, div0=0.
REQ-039 MUL 0xFF x 0xFF -> result 0xFE01; MUL 0x00 x 0x5A -> 0x0000.
REQ-040 DIV 200 / 7 -> result {0x04, 0x1C}; DIV 0xFF / 0x01 -> {0x00, 0xFF}; DIV 0x05 / 0x80 -> {0x05, 0x00}.
REQ-041 DIV 0x37 / 0x00 -> done at start+1, result {0x37, 0xFF}, div0=1, alu_rdy never 1.
REQ-042 MUL 0x0D x 0x0B with alu_gnt=0 for 5 random cycles mid-operation -> done at start+38, result 0x008F; alu_rdy=0 in every stalled cycle.
REQ-043 start pulsed while busy, then reset_n=0 for one cycle mid-DIV -> second start ignored; after reset: IDLE, result=0, no done; a new start completes normally.
